// File: rtl/hps_ioctl_bridge.sv
// Bridge from the HPS ioctl word port to NUM_CH byte-wide memory targets.
// Optional per-byte ack timeout is enabled with `define HPS_IOCTL_TIMEOUT_EN.
module hps_ioctl_bridge #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  ioctl_download,
    input  logic                  ioctl_upload,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic                  ioctl_rd,
    input  logic [24:0]           ioctl_addr,
    input  logic [15:0]           ioctl_dout,
    output logic [15:0]           ioctl_din,
    output logic                  ioctl_wait,
    output logic [NUM_CH-1:0]     mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [NUM_CH-1:0]     mem_ack,
    input  logic [NUM_CH*8-1:0]   mem_rdata,
    output logic                  xfer_done,
    output logic                  err_timeout
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
        logic [NUM_CH-1:0] oh;
        oh = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            oh[i] = (c == CH_W'(i));
        end
        return oh;
    endfunction

    state_t              state_r, state_n_s;
    logic [NUM_CH-1:0]   mem_req_r, req_n_s;
    logic                mem_we_r, we_n_s;
    logic [ADDR_W-1:0]   mem_addr_r, addr_n_s;
    logic [7:0]          mem_wdata_r, wdata_n_s;
    logic                ioctl_wait_r, wait_n_s;
    logic [15:0]         ioctl_din_r;
    logic [7:0]          wdata_hi_r;
    logic [7:0]          rd_lo_r, rd_hi_r;
    logic                dl_d_r, ul_d_r, xfer_done_r;

    logic [CH_W-1:0]     ch_sel_s;
    logic                ch_ok_s, start_wr_s, start_rd_s, start_s;
    logic                ack_s, tmo_s, byte_done_s, busy_s;
    logic [7:0]          rdata_s, byte_in_s;
    logic                unused_s;

    assign ch_sel_s    = ioctl_index[CH_W-1:0];
    assign ch_ok_s     = (32'(ch_sel_s) < 32'(NUM_CH));
    assign start_wr_s  = ioctl_wr & ioctl_download & ch_ok_s;
    assign start_rd_s  = ioctl_rd & ~ioctl_wr & ioctl_upload & ch_ok_s;
    assign start_s     = start_wr_s | start_rd_s;
    assign busy_s      = (state_r == LO) || (state_r == HI);
    // mem_req_r is one-hot on the active channel, so this also masks stray acks
    assign ack_s       = busy_s & (|(mem_ack & mem_req_r));
    assign byte_done_s = ack_s | tmo_s;
    assign byte_in_s   = ack_s ? rdata_s : 8'hFF;
    assign unused_s    = &{1'b0, ioctl_index, ioctl_addr, 32'(TIMEOUT)};

    // Read-data mux selected by the active request line
    always_comb begin
        rdata_s = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mem_req_r[i]) begin
                rdata_s = rdata_s | mem_rdata[i*8 +: 8];
            end else begin
                rdata_s = rdata_s;
            end
        end
    end

    // Next-state and next-output logic for the byte-split FSM
    always_comb begin
        state_n_s = state_r;
        req_n_s   = mem_req_r;
        we_n_s    = mem_we_r;
        addr_n_s  = mem_addr_r;
        wdata_n_s = mem_wdata_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_n_s = LO;
                    req_n_s   = ch_onehot(ch_sel_s);
                    we_n_s    = start_wr_s;
                    addr_n_s  = ioctl_addr[ADDR_W-1:0] & ~A_ONE;
                    wdata_n_s = ioctl_dout[7:0];
                end else begin
                    state_n_s = IDLE;
                end
            end
            LO: begin
                if (byte_done_s) begin
                    state_n_s = HI;
                    addr_n_s  = mem_addr_r | A_ONE;
                    wdata_n_s = wdata_hi_r;
                end else begin
                    state_n_s = LO;
                end
            end
            HI: begin
                if (byte_done_s) begin
                    state_n_s = FIN;
                    req_n_s   = {NUM_CH{1'b0}};
                end else begin
                    state_n_s = HI;
                end
            end
            FIN: begin
                state_n_s = IDLE;
            end
            default: begin
                state_n_s = IDLE;
                req_n_s   = {NUM_CH{1'b0}};
            end
        endcase
        wait_n_s = (state_n_s != IDLE);
    end

    // State and registered memory-side outputs
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            mem_req_r    <= {NUM_CH{1'b0}};
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 8'h00;
            ioctl_wait_r <= 1'b0;
        end else begin
            state_r      <= state_n_s;
            mem_req_r    <= req_n_s;
            mem_we_r     <= we_n_s;
            mem_addr_r   <= addr_n_s;
            mem_wdata_r  <= wdata_n_s;
            ioctl_wait_r <= wait_n_s;
        end
    end

    // Write high byte latch, read byte capture and read word assembly
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wdata_hi_r  <= 8'h00;
            rd_lo_r     <= 8'h00;
            rd_hi_r     <= 8'h00;
            ioctl_din_r <= 16'h0000;
        end else begin
            if (state_r == IDLE && start_s) begin
                wdata_hi_r <= ioctl_dout[15:8];
            end
            if (state_r == LO && byte_done_s && !mem_we_r) begin
                rd_lo_r <= byte_in_s;
            end
            if (state_r == HI && byte_done_s && !mem_we_r) begin
                rd_hi_r <= byte_in_s;
            end
            if (state_r == FIN && !mem_we_r) begin
                ioctl_din_r <= {rd_hi_r, rd_lo_r};
            end
        end
    end

    // Direction-flag edge detection for the completion pulse
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_d_r      <= 1'b0;
            ul_d_r      <= 1'b0;
            xfer_done_r <= 1'b0;
        end else begin
            dl_d_r      <= ioctl_download;
            ul_d_r      <= ioctl_upload;
            xfer_done_r <= (dl_d_r & ~ioctl_download) | (ul_d_r & ~ioctl_upload);
        end
    end

`ifdef HPS_IOCTL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] tmo_cnt_r;
    logic             err_timeout_r;
    logic             rise_s;

    assign rise_s = (ioctl_download & ~dl_d_r) | (ioctl_upload & ~ul_d_r);
    // Counter value TIMEOUT-1 means the request has been up TIMEOUT cycles
    assign tmo_s  = busy_s & ~ack_s & (tmo_cnt_r == CNT_W'(TIMEOUT - 1));

    // Per-byte wait counter, restarted on every state change
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (state_n_s != state_r) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (busy_s) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Sticky timeout flag, cleared when a new transfer session opens
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            err_timeout_r <= 1'b0;
        end else if (tmo_s) begin
            err_timeout_r <= 1'b1;
        end else if (rise_s) begin
            err_timeout_r <= 1'b0;
        end else begin
            err_timeout_r <= err_timeout_r;
        end
    end

    assign err_timeout = err_timeout_r;
`else
    assign tmo_s       = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign ioctl_din  = ioctl_din_r;
    assign ioctl_wait = ioctl_wait_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign xfer_done  = xfer_done_r;

endmodule

// File: tb/tb_hps_ioctl_bridge.sv
// Scoreboard bench for hps_ioctl_bridge: stimulus pushes expected accesses and
// transfer results, a negedge monitor pops and compares them.
module tb_hps_ioctl_bridge;

    localparam int NUM_CH  = 3;
    localparam int ADDR_W  = 24;
    localparam int TIMEOUT = 8;

    logic                 clk_sys = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 ioctl_download = 1'b0;
    logic                 ioctl_upload = 1'b0;
    logic [7:0]           ioctl_index = 8'h00;
    logic                 ioctl_wr = 1'b0;
    logic                 ioctl_rd = 1'b0;
    logic [24:0]          ioctl_addr = 25'h0;
    logic [15:0]          ioctl_dout = 16'h0;
    logic [15:0]          ioctl_din;
    logic                 ioctl_wait;
    logic [NUM_CH-1:0]    mem_req;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [7:0]           mem_wdata;
    logic [NUM_CH-1:0]    mem_ack = 3'b000;
    logic [NUM_CH*8-1:0]  mem_rdata = 24'h0;
    logic                 xfer_done;
    logic                 err_timeout;

    hps_ioctl_bridge #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .xfer_done(xfer_done), .err_timeout(err_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          ch;
        logic        we;
        logic [23:0] addr;
        logic [7:0]  wdata;
    } acc_t;

    typedef struct {
        logic [15:0] din;
        int          waits;
    } xfer_t;

    acc_t  acc_q[$];
    xfer_t xfer_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ack_dly = 0;
    bit    ack_en = 1'b1;
    logic [7:0] rd_lo = 8'h00;
    logic [7:0] rd_hi = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic push_acc(input int ch, input logic we, input logic [23:0] a, input logic [7:0] d);
        acc_t e;
        e.ch = ch; e.we = we; e.addr = a; e.wdata = d;
        acc_q.push_back(e);
    endtask

    task automatic push_xfer(input logic [15:0] din, input int waits);
        xfer_t x;
        x.din = din; x.waits = waits;
        xfer_q.push_back(x);
    endtask

    // Target model: acks after ack_dly idle request cycles, data by address parity
    int rcnt = 0;
    always begin
        @(posedge clk_sys);
        #1;
        mem_ack   = 3'b000;
        mem_rdata = {NUM_CH{8'hA5}};
        if (mem_req != 3'b000 && ack_en) begin
            if (rcnt >= ack_dly) begin
                mem_ack = mem_req;
                for (int i = 0; i < NUM_CH; i++)
                    if (mem_req[i]) mem_rdata[i*8 +: 8] = mem_addr[0] ? rd_hi : rd_lo;
                rcnt = 0;
            end else begin
                rcnt++;
            end
        end else begin
            rcnt = 0;
        end
    end

    // Monitor: handshakes against acc_q, end of each stall against xfer_q
    int wcnt = 0;
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            wcnt = 0;
        end else begin
            if ((mem_req & mem_ack) != 3'b000) begin
                if (acc_q.size() == 0) begin
                    fail_now($sformatf("acc_unexpected req=%b addr=0x%0h", mem_req, mem_addr));
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    chk("acc_req", 64'(mem_req), 64'(1) << e.ch);
                    chk("acc_we", 64'(mem_we), 64'(e.we));
                    chk("acc_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we) chk("acc_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
            if (ioctl_wait) begin
                wcnt++;
            end else if (wcnt > 0) begin
                if (xfer_q.size() == 0) begin
                    fail_now("xfer_unexpected");
                end else begin
                    xfer_t x;
                    x = xfer_q.pop_front();
                    chk("xfer_din", 64'(ioctl_din), 64'(x.din));
                    chk("xfer_wait_cycles", 64'(wcnt), 64'(x.waits));
                end
                wcnt = 0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input bit wr, input bit rd, input int idx, input logic [24:0] a, input logic [15:0] d);
        @(posedge clk_sys);
        #1;
        ioctl_index = 8'(idx);
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = wr;
        ioctl_rd    = rd;
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        ioctl_rd = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge clk_sys);
            #2;
            if (acc_q.size() == 0 && xfer_q.size() == 0 && !ioctl_wait) return;
        end
        fail_now($sformatf("%s_timeout acc_left=%0d xfer_left=%0d", name, acc_q.size(), xfer_q.size()));
        acc_q.delete();
        xfer_q.delete();
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({mem_req, mem_we, mem_addr, mem_wdata, ioctl_din, ioctl_wait, xfer_done, err_timeout});
    endfunction

    initial begin
        int seen;
        bit found;

        cycles(3);
        chk("reset_outputs", all_outs(), 64'h0);
        reset_n = 1'b1;
        cycles(2);

        // Zero-wait write, then a write with 1-cycle ack delay and high address bits
        ioctl_download = 1'b1;
        cycles(2);
        ack_dly = 0;
        push_acc(1, 1'b1, 24'h000100, 8'hEF);
        push_acc(1, 1'b1, 24'h000101, 8'hBE);
        push_xfer(16'h0000, 3);
        strobe(1'b1, 1'b0, 1, 25'h0000100, 16'hBEEF);
        drain("write_zero_wait", 50);

        ack_dly = 1;
        push_acc(0, 1'b1, 24'hABCDE0, 8'hD2);
        push_acc(0, 1'b1, 24'hABCDE1, 8'hC3);
        push_xfer(16'h0000, 5);
        strobe(1'b1, 1'b0, 0, 25'h1ABCDE1, 16'hC3D2);
        drain("write_delay1", 50);

        // Out-of-range channel and a read without upload must stay silent
        seen = 0;
        strobe(1'b1, 1'b0, 3, 25'h0000010, 16'h1111);
        strobe(1'b0, 1'b1, 1, 25'h0000020, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            if (mem_req != 3'b000 || ioctl_wait) seen++;
        end
        chk("ignored_strobe_quiet", 64'(seen), 64'h0);

        // Falling download edge gives a single-cycle done pulse
        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("done_before", 64'(xfer_done), 64'h0);
        @(negedge clk_sys);
        chk("done_pulse", 64'(xfer_done), 64'h1);
        @(negedge clk_sys);
        chk("done_after", 64'(xfer_done), 64'h0);

        // Read with two-cycle ack delay on both bytes
        ioctl_upload = 1'b1;
        cycles(2);
        ack_dly = 2;
        rd_lo = 8'h34;
        rd_hi = 8'h12;
        push_acc(2, 1'b0, 24'h000040, 8'h00);
        push_acc(2, 1'b0, 24'h000041, 8'h00);
        push_xfer(16'h1234, 7);
        strobe(1'b0, 1'b1, 2, 25'h0000040, 16'h0000);
        drain("read_delay2", 50);
        chk("read_din_hold", 64'(ioctl_din), 64'h1234);

        // Simultaneous write and read strobes: only the write happens
        ioctl_download = 1'b1;
        cycles(2);
        ack_dly = 0;
        push_acc(1, 1'b1, 24'h000200, 8'h3C);
        push_acc(1, 1'b1, 24'h000201, 8'h5A);
        push_xfer(16'h1234, 3);
        strobe(1'b1, 1'b1, 1, 25'h0000200, 16'h5A3C);
        drain("arbitration", 50);

        @(posedge clk_sys);
        #1;
        ioctl_download = 1'b0;
        ioctl_upload   = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            if (xfer_done) seen++;
        end
        chk("done_both_single", 64'(seen), 64'h1);

`ifdef HPS_IOCTL_TIMEOUT_EN
        // No ack at all: each byte times out after TIMEOUT cycles
        ioctl_upload = 1'b1;
        cycles(2);
        ack_en = 1'b0;
        push_xfer(16'hFFFF, 2 * TIMEOUT + 1);
        strobe(1'b0, 1'b1, 0, 25'h0000010, 16'h0000);
        drain("timeout_read", 100);
        chk("timeout_flag_set", 64'(err_timeout), 64'h1);
        ack_en = 1'b1;
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b1;
        cycles(2);
        chk("timeout_flag_cleared", 64'(err_timeout), 64'h0);
`else
        chk("timeout_flag_tied", 64'(err_timeout), 64'h0);
`endif

        // Asynchronous reset while the high byte is pending
        ioctl_download = 1'b1;
        cycles(2);
        ack_dly = 3;
        push_acc(0, 1'b1, 24'h000300, 8'h88);
        strobe(1'b1, 1'b0, 0, 25'h0000300, 16'h7788);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_sys);
            if (mem_req != 3'b000 && mem_addr[0]) found = 1'b1;
        end
        if (!found) fail_now("reset_mid_no_hi_byte");
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_mid_outputs", all_outs(), 64'h0);
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        ack_dly = 0;
        push_acc(0, 1'b1, 24'h000302, 8'h22);
        push_acc(0, 1'b1, 24'h000303, 8'h11);
        push_xfer(16'h0000, 3);
        strobe(1'b1, 1'b0, 0, 25'h0000302, 16'h1122);
        drain("write_after_reset", 50);

        cycles(3);
        chk("acc_queue_empty", 64'(acc_q.size()), 64'h0);
        chk("xfer_queue_empty", 64'(xfer_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
